monster_fire_sched: RTL and testbench
=====================================

// Module: monster_fire_sched
// PURPOSE
//  Schedules enemy shots for the Space Monsters game: decides when a monster fires, which live
//  monster fires (round-robin) and which free projectile slot carries the shot.
//  Sits between the game state machine (enable, level) and the projectile datapath inside the block
//  controller (slot_busy, fire handshake). The fire rate is level-dependent and is paced by VGA frame ticks.
// PARAMETERS
//  NUM_MON      5    number of monsters (1..8)
//  NUM_SLOTS    2    enemy projectile slots in datapath (1..4)
//  COOLDOWN_L1  60   frames between shots, level 0 (1..255)
//  COOLDOWN_L2  30   frames between shots, level 1 (1..255)
// PORTS
//  clk          in   1                    system clock
//  rst          in   1                    async reset, active-high
//  enable       in   1                    high while game is in L1/L2 play states
//  level        in   1                    0=L1, 1=L2; selects cooldown
//  frame_tick   in   1                    1-cycle pulse per frame (vCount wrap)
//  alive        in   NUM_MON              bit i=1: monster i not destroyed
//  slot_busy    in   NUM_SLOTS            bit j=1: slot j projectile in flight
//  fire_valid   out  1                    shot request, registered
//  fire_ready   in   1                    datapath accepts shot this cycle
//  fire_mon     out  clog2(NUM_MON)       index of firing monster
//  fire_slot    out  max(1,clog2(NUM_SLOTS)) projectile slot to load
// BEHAVIOUR
//  Reset: state=IDLE, fire_valid=0, fire_mon=0, fire_slot=0, cd_cnt=0, rr_ptr=NUM_MON-1.
//  States: IDLE, COOLDOWN, SELECT, ISSUE (one-hot, from pkg).
//  IDLE: on enable=1 -> cd_cnt<=cooldown(level), go COOLDOWN.
//  COOLDOWN: cd_cnt decrements only on frame_tick; the tick taking cd_cnt 1->0 -> SELECT next cycle.
//  SELECT: requires |alive && ~&slot_busy. If both hold: fire_mon <= first alive index strictly after
//   rr_ptr, wrapping NUM_MON-1 -> 0; fire_slot <= lowest-index free slot; fire_valid<=1; go ISSUE.
//   Otherwise stay in SELECT (no tick dependence) until both hold.
//  ISSUE: fire_valid, fire_mon and fire_slot held stable until fire_valid&&fire_ready; on handshake:
//   rr_ptr<=fire_mon, fire_valid<=0, cd_cnt<=cooldown(level sampled at handshake), go COOLDOWN.
//   Changes on alive/slot_busy during ISSUE do not alter the request; the datapath discards stale shots.
//  Latency: SELECT->fire_valid high is 1 cycle; after a handshake, fire_valid is low from the next cycle.
//  enable=0 in any state: next cycle state=IDLE, fire_valid=0; rr_ptr is kept. This covers abort mid-handshake.
//  frame_tick coincident with SELECT/ISSUE is ignored; a tick in the same cycle as the COOLDOWN load is ignored.
//  A single alive monster fires every time; rr_ptr pointing at a dead monster is legal (the search skips it).
//  cd_cnt is 8-bit; a cooldown parameter of 0 is illegal (assertion in simulation).
// CONFIGURATION
//  FIRE_STATS_EN defined: extra output shots_fired[15:0], reset 0, +1 per handshake, saturates at 16'hFFFF,
//   and is not cleared by enable.
//  FIRE_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package space_monsters_pkg: fsched_state_t one-hot enum, MAX_MON=8, MAX_SLOTS=4,
//   level encoding constants LVL1=0, LVL2=1.
//  Sub-module rr_picker (combinational): inputs req[N], ptr; outputs grant_idx, any.
//   It is instanced for monster selection.
//  The free-slot choice is an inline priority encoder.
// TESTING
//  1 Reset, enable=1, level=0, alive=5'b11111, slot_busy=0, ready=1: first fire_valid exactly after 60 ticks
//    plus 1 cycle, with fire_mon=0 and fire_slot=0; following shots go 1,2,3,4,0.
//  2 level=1: the interval between handshakes is 30 ticks; alive=5'b10100 -> fire_mon sequence 2,4,2,4.
//  3 slot_busy=2'b11 at cooldown end: fire_valid stays 0; releasing slot 1 -> fire_valid with fire_slot=1 next cycle.
//  4 ready=0 for 7 cycles: fire_valid, fire_mon and fire_slot are stable all 7 cycles; handshake on cycle 8
//    reloads the cooldown, and alive=0 then holds the block in SELECT.
//  5 enable dropped during ISSUE: fire_valid=0 next cycle, state=IDLE; re-enable resumes from rr_ptr+1.
//  6 rst asserted mid-COOLDOWN: outputs go to reset values immediately; with FIRE_STATS_EN, shots_fired=0.

Source files
------------

// File: rtl/space_monsters_pkg.sv
// Shared types and constants for the Space Monsters block controller.
package space_monsters_pkg;

  localparam int MAX_MON   = 8;
  localparam int MAX_SLOTS = 4;

  localparam logic LVL1 = 1'b0;
  localparam logic LVL2 = 1'b1;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    COOLDOWN = 4'b0010,
    SELECT   = 4'b0100,
    ISSUE    = 4'b1000
  } fsched_state_t;

endpackage

// File: rtl/monster_fire_sched_rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping N-1 -> 0.
// If only ptr itself is requesting, ptr is granted on the final step of the search.
module rr_picker #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  int k;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    k         = 0;
    for (int i = N; i >= 1; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) grant_idx = W'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/monster_fire_sched.sv
// Enemy shot scheduler: level-paced cooldown, round-robin shooter, lowest free slot.
// Optional FIRE_STATS_EN adds a saturating shots_fired counter output.
module monster_fire_sched
  import space_monsters_pkg::*;
#(
  parameter int NUM_MON     = 5,
  parameter int NUM_SLOTS   = 2,
  parameter int COOLDOWN_L1 = 60,
  parameter int COOLDOWN_L2 = 30,
  localparam int MON_W  = (NUM_MON   > 1) ? $clog2(NUM_MON)   : 1,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 level,
  input  logic                 frame_tick,
  input  logic [NUM_MON-1:0]   alive,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic                 fire_valid,
  input  logic                 fire_ready,
  output logic [MON_W-1:0]     fire_mon,
`ifdef FIRE_STATS_EN
  output logic [SLOT_W-1:0]    fire_slot,
  output logic [15:0]          shots_fired
`else
  output logic [SLOT_W-1:0]    fire_slot
`endif
);

  if (COOLDOWN_L1 < 1 || COOLDOWN_L1 > 255 || COOLDOWN_L2 < 1 || COOLDOWN_L2 > 255) begin : g_bad_cd
    $error("monster_fire_sched: cooldown parameters must be 1..255");
  end
  if (NUM_MON < 1 || NUM_MON > MAX_MON || NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS) begin : g_bad_size
    $error("monster_fire_sched: NUM_MON/NUM_SLOTS out of range");
  end

  localparam logic [7:0] CD_L1 = 8'(COOLDOWN_L1);
  localparam logic [7:0] CD_L2 = 8'(COOLDOWN_L2);

  fsched_state_t       state;
  logic [7:0]          cd_cnt;
  logic [7:0]          cd_load;
  logic [MON_W-1:0]    rr_ptr;
  logic [MON_W-1:0]    mon_grant;
  logic                mon_any;
  logic [SLOT_W-1:0]   free_slot;
  logic                slot_any;

  assign cd_load  = (level == LVL1) ? CD_L1 : CD_L2;
  assign slot_any = ~&slot_busy;

  rr_picker #(.N(NUM_MON), .W(MON_W)) u_mon_pick (
    .req       (alive),
    .ptr       (rr_ptr),
    .grant_idx (mon_grant),
    .any       (mon_any)
  );

  always_comb begin
    free_slot = '0;
    for (int j = NUM_SLOTS - 1; j >= 0; j--)
      if (!slot_busy[j]) free_slot = SLOT_W'(j);
  end

  // Dropping enable wins over everything, including a handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fire_valid <= 1'b0;
      fire_mon   <= '0;
      fire_slot  <= '0;
      cd_cnt     <= '0;
      rr_ptr     <= MON_W'(NUM_MON - 1);
    end else if (!enable) begin
      state      <= IDLE;
      fire_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cd_cnt <= cd_load;
          state  <= COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_tick) begin
            cd_cnt <= cd_cnt - 8'd1;
            if (cd_cnt == 8'd1) state <= SELECT;
          end
        end
        SELECT: begin
          if (mon_any && slot_any) begin
            fire_mon   <= mon_grant;
            fire_slot  <= free_slot;
            fire_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire_ready) begin
            rr_ptr     <= fire_mon;
            fire_valid <= 1'b0;
            cd_cnt     <= cd_load;
            state      <= COOLDOWN;
          end
        end
        default: begin
          state      <= IDLE;
          fire_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIRE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shots_fired <= '0;
    else if (fire_valid && fire_ready && shots_fired != 16'hFFFF)
      shots_fired <= shots_fired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_monster_fire_sched.sv
// Directed bench for monster_fire_sched: vector table of shots plus corner-case sequences.
module tb_monster_fire_sched;
  import space_monsters_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       level;
  logic       frame_tick;
  logic [4:0] alive;
  logic [1:0] slot_busy;
  logic       fire_valid;
  logic       fire_ready;
  logic [2:0] fire_mon;
  logic [0:0] fire_slot;
`ifdef FIRE_STATS_EN
  logic [15:0] shots_fired;
`endif

  int tests = 0;
  int fails = 0;
  int hs    = 0;

  always #5 clk = ~clk;

  monster_fire_sched #(.NUM_MON(5), .NUM_SLOTS(2), .COOLDOWN_L1(60), .COOLDOWN_L2(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .level      (level),
    .frame_tick (frame_tick),
    .alive      (alive),
    .slot_busy  (slot_busy),
    .fire_valid (fire_valid),
    .fire_ready (fire_ready),
    .fire_mon   (fire_mon),
`ifdef FIRE_STATS_EN
    .fire_slot  (fire_slot),
    .shots_fired(shots_fired)
`else
    .fire_slot  (fire_slot)
`endif
  );

  typedef struct {
    logic       lvl;
    logic [4:0] alive;
    logic [1:0] busy;
    int         ticks;
    logic [2:0] mon;
    logic       slot;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n tick pulses with a quiet cycle between them; fire_valid must stay low throughout,
  // including right after the final tick (block is in SELECT then).
  task automatic do_ticks(input int n);
    bit early = 1'b0;
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (fire_valid) early = 1'b1;
      if (k < n - 1) begin
        step();
        if (fire_valid) early = 1'b1;
      end
    end
    chk("no_early_fire", 32'(early), 32'd0);
  endtask

  task automatic run_shot(input int n, input logic [2:0] mon, input logic slot, input logic next_lvl);
    do_ticks(n);
    step();
    chk("fire_valid_up", 32'(fire_valid), 32'd1);
    chk("fire_mon", 32'(fire_mon), 32'(mon));
    chk("fire_slot", 32'(fire_slot), 32'(slot));
    level = next_lvl;
    step();
    hs++;
    chk("fire_valid_down", 32'(fire_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd2, 1'b0};
    vecs[3]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd3, 1'b0};
    vecs[4]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd4, 1'b0};
    vecs[5]  = '{1'b0, 5'b11111, 2'b00, 60, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 5'b10100, 2'b00, 30, 3'd2, 1'b0};
    vecs[7]  = '{1'b1, 5'b10100, 2'b01, 30, 3'd4, 1'b1};
    vecs[8]  = '{1'b1, 5'b10100, 2'b10, 30, 3'd2, 1'b0};
    vecs[9]  = '{1'b1, 5'b10100, 2'b00, 30, 3'd4, 1'b0};
    vecs[10] = '{1'b1, 5'b01000, 2'b10, 30, 3'd3, 1'b0};
    vecs[11] = '{1'b1, 5'b01000, 2'b01, 30, 3'd3, 1'b1};
    vecs[12] = '{1'b0, 5'b11111, 2'b00, 60, 3'd4, 1'b0};

    rst = 1'b1; enable = 1'b0; level = 1'b0; frame_tick = 1'b0;
    alive = 5'b11111; slot_busy = 2'b00; fire_ready = 1'b1;
    step(); step();
    chk("rst_fire_valid", 32'(fire_valid), 32'd0);
    chk("rst_fire_mon", 32'(fire_mon), 32'd0);
    chk("rst_fire_slot", 32'(fire_slot), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef FIRE_STATS_EN
    chk("rst_shots", 32'(shots_fired), 32'd0);
`endif

    rst = 1'b0; enable = 1'b1; level = vecs[0].lvl;
    step();

    // Level is set ahead of each handshake so the reload uses the next vector's cooldown.
    for (int i = 0; i < NV; i++) begin
      alive     = vecs[i].alive;
      slot_busy = vecs[i].busy;
      run_shot(vecs[i].ticks, vecs[i].mon, vecs[i].slot,
               (i + 1 < NV) ? vecs[i + 1].lvl : vecs[i].lvl);
    end

    // All slots busy at cooldown end: hold in SELECT until slot 1 frees.
    alive = 5'b11111; slot_busy = 2'b11;
    do_ticks(60);
    begin
      bit any_fv = 1'b0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (fire_valid) any_fv = 1'b1;
      end
      chk("busy_hold", 32'(any_fv), 32'd0);
    end
    slot_busy = 2'b01; fire_ready = 1'b0;
    step();
    chk("release_fv", 32'(fire_valid), 32'd1);
    chk("release_slot", 32'(fire_slot), 32'd1);
    chk("release_mon", 32'(fire_mon), 32'd0);

    // Backpressure: request frozen while inputs change underneath it.
    slot_busy = 2'b00; alive = 5'b11110;
    begin
      bit moved = 1'b0;
      for (int c = 0; c < 7; c++) begin
        step();
        if (fire_valid !== 1'b1 || fire_mon !== 3'd0 || fire_slot !== 1'b1) moved = 1'b1;
      end
      chk("stall_stable", 32'(moved), 32'd0);
    end
    fire_ready = 1'b1;
    step();
    hs++;
    chk("stall_hs_fv", 32'(fire_valid), 32'd0);

    // Nobody alive: cooldown expires, block waits in SELECT.
    alive = 5'b00000;
    do_ticks(60);
    begin
      bit any_fv = 1'b0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (fire_valid) any_fv = 1'b1;
      end
      chk("dead_hold", 32'(any_fv), 32'd0);
    end
    chk("dead_state", 32'(dut.state), 32'(SELECT));

    // Abort during ISSUE, then resume at the same round-robin position.
    alive = 5'b11111; fire_ready = 1'b0;
    step();
    chk("abort_pre_fv", 32'(fire_valid), 32'd1);
    chk("abort_pre_mon", 32'(fire_mon), 32'd1);
    enable = 1'b0;
    step();
    chk("abort_fv", 32'(fire_valid), 32'd0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    enable = 1'b1; fire_ready = 1'b1;
    step();
    run_shot(60, 3'd1, 1'b0, 1'b0);

`ifdef FIRE_STATS_EN
    chk("shots_count", 32'(shots_fired), 32'(hs));
`endif

    // Asynchronous reset in the middle of a cooldown.
    do_ticks(10);
    #2 rst = 1'b1;
    #1;
    chk("arst_fire_mon", 32'(fire_mon), 32'd0);
    chk("arst_fire_valid", 32'(fire_valid), 32'd0);
    chk("arst_fire_slot", 32'(fire_slot), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(IDLE));
`ifdef FIRE_STATS_EN
    chk("arst_shots", 32'(shots_fired), 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    run_shot(60, 3'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
